// File: rtl/xnor_pkg.sv
// Shared definitions for the binarized dot-product datapath: width limits,
// constant sizing helpers and the accumulator stage state encoding.
package xnor_pkg;

    localparam int MAX_WIDTH = 48;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bits needed to hold any count from 0 up to maxValue inclusive.
    function automatic int count_bits(input int maxValue);
        return clog2(maxValue + 1);
    endfunction

    // IDLE: no partial group, ACCUM: partial group in progress,
    // HOLD: final beat waiting for the output register to free up.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/bit_popcount.sv
// Combinational population count of one XNOR beat, built as a balanced
// binary adder tree over the input bits padded to a power of two.
module bit_popcount
    import xnor_pkg::*;
#(
    parameter int width = 48,
    localparam int CountWidth = count_bits(width)
) (
    input  logic [width-1:0]      data_i,
    output logic [CountWidth-1:0] count_o
);

    localparam int Levels = clog2(width);
    localparam int Leaves = 1 << Levels;

    // Level 0 holds single bits; each higher level sums adjacent pairs.
    always_comb begin
        logic [CountWidth-1:0] tree [0:Levels][0:Leaves-1];
        for (int l = 0; l <= Levels; l++) begin
            for (int j = 0; j < Leaves; j++) begin
                tree[l][j] = '0;
            end
        end
        for (int j = 0; j < width; j++) begin
            tree[0][j] = CountWidth'(data_i[j]);
        end
        for (int l = 1; l <= Levels; l++) begin
            for (int j = 0; j < (Leaves >> l); j++) begin
                tree[l][j] = tree[l-1][2*j] + tree[l-1][2*j+1];
            end
        end
        count_o = tree[Levels][0];
    end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Popcount accumulator for binarized dot products: counts the ones in each
// XNOR beat, sums them over a fixed group of beats and presents the match
// count and the signed +/-1 dot product on a valid/ready output.
module xnor_popcount_acc
    import xnor_pkg::*;
#(
    parameter int width     = 48,
    parameter int beats     = 4,
    parameter int acc_width = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [acc_width-1:0] out_count,
    output logic [acc_width:0]   out_dot
);

    localparam int PcWidth  = count_bits(width);
    localparam int CntWidth = (beats > 1) ? clog2(beats) : 1;
    localparam logic [CntWidth-1:0] LastBeat  = CntWidth'(beats - 1);
    localparam logic [acc_width:0]  TotalWide = (acc_width + 1)'(width * beats);

    if (width < 1 || width > MAX_WIDTH) begin : g_bad_width
        $error("xnor_popcount_acc: width %0d outside 1..%0d", width, MAX_WIDTH);
    end
    if (beats < 1) begin : g_bad_beats
        $error("xnor_popcount_acc: beats %0d must be at least 1", beats);
    end
    if (acc_width < count_bits(width * beats)) begin : g_bad_acc_width
        $error("xnor_popcount_acc: acc_width %0d too small for %0d x %0d bits",
               acc_width, width, beats);
    end

    logic [PcWidth-1:0]   pcCount_d;
    logic [PcWidth-1:0]   pcCount_q;
    logic                 pcValid_q;
    logic [acc_width-1:0] accSum_d;
    logic [acc_width-1:0] accSum_q;
    logic [CntWidth-1:0]  beatCnt_d;
    logic [CntWidth-1:0]  beatCnt_q;
    acc_state_t           state_d;
    acc_state_t           state_q;
    logic                 outValid_q;
    logic [acc_width-1:0] outCount_q;
    logic [acc_width:0]   dot_d;
    logic [acc_width:0]   outDot_q;

    logic                 finalBeat;
    logic                 stall;
    logic                 advance;
    logic                 loadResult;
    logic                 takeBeat;
    logic [acc_width-1:0] groupSum;

    bit_popcount #(.width(width)) u_popcount (
        .data_i  (in_data),
        .count_o (pcCount_d)
    );

    assign in_ready = !reset && !clear && (!pcValid_q || advance);
    assign takeBeat = in_valid && in_ready;

    // Stage 2 next state: a final beat may only retire once the output
    // register is free or being emptied this cycle; clear always wins.
    always_comb begin
        finalBeat  = pcValid_q && (beatCnt_q == LastBeat);
        stall      = finalBeat && outValid_q && !out_ready;
        advance    = !stall;
        groupSum   = ((state_q == IDLE) ? '0 : accSum_q) + acc_width'(pcCount_q);
        loadResult = finalBeat && advance && !clear;
        dot_d      = {groupSum, 1'b0} - TotalWide;
        state_d    = state_q;
        accSum_d   = accSum_q;
        beatCnt_d  = beatCnt_q;
        if (clear) begin
            state_d   = IDLE;
            accSum_d  = '0;
            beatCnt_d = '0;
        end else if (pcValid_q && advance) begin
            if (finalBeat) begin
                state_d   = IDLE;
                accSum_d  = '0;
                beatCnt_d = '0;
            end else begin
                state_d   = ACCUM;
                accSum_d  = groupSum;
                beatCnt_d = beatCnt_q + CntWidth'(1);
            end
        end else if (stall) begin
            state_d = HOLD;
        end
    end

    // Stage 1: register the popcount of each accepted beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcValid_q <= 1'b0;
            pcCount_q <= '0;
        end else begin
            if (clear) begin
                pcValid_q <= 1'b0;
            end else if (!pcValid_q || advance) begin
                pcValid_q <= in_valid;
            end
            if (takeBeat) begin
                pcCount_q <= pcCount_d;
            end
        end
    end

    // Stage 2 FSM with the registered output handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            accSum_q   <= '0;
            beatCnt_q  <= '0;
            outValid_q <= 1'b0;
            outCount_q <= '0;
            outDot_q   <= '0;
        end else begin
            state_q   <= state_d;
            accSum_q  <= accSum_d;
            beatCnt_q <= beatCnt_d;
            if (loadResult) begin
                outValid_q <= 1'b1;
                outCount_q <= groupSum;
                outDot_q   <= dot_d;
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_count = outCount_q;
    assign out_dot   = outDot_q;

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Bench for xnor_popcount_acc: three instances (8x2, 48x4, 8x4) checked
// every cycle against a group-sum reference model, plus directed cases.
module tb_xnor_popcount_acc;

    localparam int NumDut = 3;
    localparam int AccW   = 16;
    localparam int QDepth = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              clearSig [NumDut];
    logic              inValid  [NumDut];
    logic              inReady  [NumDut];
    logic [47:0]       inData   [NumDut];
    logic              outValid [NumDut];
    logic              outReady [NumDut];
    logic [AccW-1:0]   outCount [NumDut];
    logic [AccW:0]     outDot   [NumDut];

    int partialSum  [NumDut];
    int partialN    [NumDut];
    int expCount    [NumDut][QDepth];
    int head        [NumDut];
    int tail        [NumDut];
    int resultsSeen [NumDut];
    int readyLow    [NumDut];
    bit tookBeat    [NumDut];
    int checkCount = 0;
    int passCount  = 0;

    always #5 clock = ~clock;

    xnor_popcount_acc #(.width(8), .beats(2), .acc_width(AccW)) dut0 (
        .clock(clock), .reset(reset), .clear(clearSig[0]),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0][7:0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_count(outCount[0]), .out_dot(outDot[0])
    );

    xnor_popcount_acc #(.width(48), .beats(4), .acc_width(AccW)) dut1 (
        .clock(clock), .reset(reset), .clear(clearSig[1]),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_count(outCount[1]), .out_dot(outDot[1])
    );

    xnor_popcount_acc #(.width(8), .beats(4), .acc_width(AccW)) dut2 (
        .clock(clock), .reset(reset), .clear(clearSig[2]),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2][7:0]),
        .out_valid(outValid[2]), .out_ready(outReady[2]),
        .out_count(outCount[2]), .out_dot(outDot[2])
    );

    function automatic int widthOf(input int i);
        return (i == 1) ? 48 : 8;
    endfunction

    function automatic int beatsOf(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int popc(input logic [47:0] d, input int w);
        int n;
        n = 0;
        for (int b = 0; b < w; b++) begin
            n += int'(d[b]);
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input longint got, input longint exp);
        checkCount++;
        if (got == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model and per-cycle compare, sampled on the falling edge
    // so everything seen here is what the next rising edge will act on.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < NumDut; i++) begin
                head[i]       = 0;
                tail[i]       = 0;
                partialSum[i] = 0;
                partialN[i]   = 0;
                checkOutput($sformatf("dut%0d reset out_valid", i), outValid[i], 0);
                checkOutput($sformatf("dut%0d reset out_count", i), outCount[i], 0);
                checkOutput($sformatf("dut%0d reset out_dot", i), outDot[i], 0);
                checkOutput($sformatf("dut%0d reset in_ready", i), inReady[i], 0);
            end
        end else begin
            for (int i = 0; i < NumDut; i++) begin
                if (outValid[i]) begin
                    int pending;
                    pending = tail[i] - head[i];
                    checkOutput($sformatf("dut%0d result expected", i), longint'(pending != 0), 1);
                    if (pending != 0) begin
                        int e;
                        e = expCount[i][head[i] % QDepth];
                        checkOutput($sformatf("dut%0d out_count", i), outCount[i], e);
                        checkOutput($sformatf("dut%0d out_dot", i),
                                    longint'($signed(outDot[i])),
                                    2 * e - widthOf(i) * beatsOf(i));
                        if (outReady[i]) begin
                            head[i]++;
                            resultsSeen[i]++;
                        end
                    end
                end
                if (inValid[i] && !inReady[i]) begin
                    readyLow[i]++;
                end
                if (clearSig[i]) begin
                    partialSum[i] = 0;
                    partialN[i]   = 0;
                end else if (inValid[i] && inReady[i]) begin
                    partialSum[i] += popc(inData[i], widthOf(i));
                    partialN[i]++;
                    if (partialN[i] == beatsOf(i)) begin
                        expCount[i][tail[i] % QDepth] = partialSum[i];
                        tail[i]++;
                        partialSum[i] = 0;
                        partialN[i]   = 0;
                    end
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic applyStimulus(input int i, input logic [47:0] d);
        bit took;
        int guard;
        took  = 1'b0;
        guard = 0;
        inValid[i] = 1'b1;
        inData[i]  = d;
        do begin
            @(negedge clock);
            took = inReady[i];
            @(posedge clock);
            #1;
            guard++;
        end while (!took && guard < 50);
        checkOutput($sformatf("dut%0d beat accepted", i), took, 1);
        inValid[i] = 1'b0;
    endtask

    task automatic waitValid(input int i, input int n);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!outValid[i] && k < n);
        checkOutput($sformatf("dut%0d result arrives", i), outValid[i], 1);
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int g1;
        logic [47:0] beat;

        reset = 1'b1;
        for (int i = 0; i < NumDut; i++) begin
            clearSig[i]    = 1'b0;
            inValid[i]     = 1'b0;
            inData[i]      = '0;
            outReady[i]    = 1'b1;
            resultsSeen[i] = 0;
            readyLow[i]    = 0;
            tookBeat[i]    = 1'b0;
            partialSum[i]  = 0;
            partialN[i]    = 0;
            head[i]        = 0;
            tail[i]        = 0;
        end
        repeat (2) @(negedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        @(negedge clock);
        checkOutput("in_ready after reset release", inReady[0], 1);
        nextCycle();

        $display("[TB] test 1: all-ones pair, latency and single-cycle valid");
        applyStimulus(0, 48'hFF);
        applyStimulus(0, 48'hFF);
        @(negedge clock);
        checkOutput("t1 no result one cycle after final beat", outValid[0], 0);
        @(negedge clock);
        checkOutput("t1 out_valid two cycles after final beat", outValid[0], 1);
        checkOutput("t1 out_count literal", outCount[0], 16);
        checkOutput("t1 out_dot literal", longint'($signed(outDot[0])), 16);
        @(negedge clock);
        checkOutput("t1 out_valid lasts one cycle", outValid[0], 0);
        nextCycle();

        $display("[TB] test 2: negative dot product");
        applyStimulus(0, 48'h00);
        applyStimulus(0, 48'h0F);
        waitValid(0, 4);
        checkOutput("t2 out_count literal", outCount[0], 4);
        checkOutput("t2 out_dot literal", longint'($signed(outDot[0])), -8);
        nextCycle();

        $display("[TB] test 3: 12 random 48-bit beats streamed");
        readyLow[1] = 0;
        seen = resultsSeen[1];
        for (int b = 0; b < 12; b++) begin
            applyStimulus(1, rand48());
        end
        repeat (4) nextCycle();
        checkOutput("t3 in_ready never low", readyLow[1], 0);
        checkOutput("t3 results emitted", resultsSeen[1] - seen, 3);

        $display("[TB] test 4: output stall backs up the input");
        seen = resultsSeen[1];
        outReady[1] = 1'b0;
        g1 = 0;
        for (int b = 0; b < 8; b++) begin
            beat = rand48();
            if (b < 4) begin
                g1 += popc(beat, 48);
            end
            applyStimulus(1, beat);
        end
        @(negedge clock);
        checkOutput("t4 in_ready drops", inReady[1], 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checkOutput("t4 out_valid held", outValid[1], 1);
            checkOutput("t4 first result held", outCount[1], g1);
        end
        nextCycle();
        outReady[1] = 1'b1;
        repeat (6) nextCycle();
        checkOutput("t4 both results emitted", resultsSeen[1] - seen, 2);
        checkOutput("t4 nothing left pending", tail[1] - head[1], 0);

        $display("[TB] test 5: clear discards the partial group");
        seen = resultsSeen[2];
        applyStimulus(2, 48'hFF);
        clearSig[2] = 1'b1;
        @(negedge clock);
        checkOutput("t5 in_ready low during clear", inReady[2], 0);
        @(posedge clock);
        #1 clearSig[2] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(2, 48'hFF);
        end
        waitValid(2, 4);
        checkOutput("t5 out_count literal", outCount[2], 32);
        checkOutput("t5 out_dot literal", longint'($signed(outDot[2])), 32);
        nextCycle();
        repeat (3) nextCycle();
        checkOutput("t5 single result", resultsSeen[2] - seen, 1);

        $display("[TB] test 6: asynchronous reset mid-group and mid-handshake");
        outReady[0] = 1'b0;
        applyStimulus(0, 48'hFF);
        applyStimulus(0, 48'hFF);
        repeat (3) nextCycle();
        checkOutput("t6 result waiting before reset", outValid[0], 1);
        applyStimulus(1, 48'hFFFF_FFFF_FFFF);
        applyStimulus(1, 48'hFFFF_FFFF_FFFF);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NumDut; i++) begin
            checkOutput($sformatf("t6 dut%0d out_valid cleared at once", i), outValid[i], 0);
            checkOutput($sformatf("t6 dut%0d out_count cleared at once", i), outCount[i], 0);
            checkOutput($sformatf("t6 dut%0d out_dot cleared at once", i), outDot[i], 0);
            checkOutput($sformatf("t6 dut%0d in_ready low in reset", i), inReady[i], 0);
        end
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(negedge clock);
        checkOutput("t6 in_ready after release", inReady[1], 1);
        nextCycle();
        outReady[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 48'hFFFF_FFFF_FFFF);
        end
        waitValid(1, 4);
        checkOutput("t6 fresh group count", outCount[1], 192);
        checkOutput("t6 fresh group dot", longint'($signed(outDot[1])), 192);
        nextCycle();

        $display("[TB] test 7: random traffic with random backpressure");
        for (int i = 0; i < NumDut; i++) begin
            tookBeat[i] = 1'b0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NumDut; i++) begin
                if (!inValid[i] || tookBeat[i]) begin
                    inValid[i] = ($urandom_range(0, 3) != 0);
                    inData[i]  = rand48();
                end
                outReady[i] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clock);
            for (int i = 0; i < NumDut; i++) begin
                tookBeat[i] = inValid[i] && inReady[i];
            end
            @(posedge clock);
            #1;
        end
        for (int i = 0; i < NumDut; i++) begin
            inValid[i]  = 1'b0;
            outReady[i] = 1'b1;
        end
        repeat (10) nextCycle();
        for (int i = 0; i < NumDut; i++) begin
            checkOutput($sformatf("t7 dut%0d all results drained", i), tail[i] - head[i], 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/xnor_popcount_acc.md
# xnor_popcount_acc

Downstream consumer of the DSP XNOR stage for binarized dot products. It takes one `width`-bit XNOR result per accepted beat, counts the ones, and accumulates the counts over a fixed group of `beats` beats. At the end of each group it presents both the raw match count and the signed ±1 dot product on a valid/ready output. It sits between the DSP XNOR output and the activation/threshold logic.

## Interface
- `width`, 48: bits per XNOR beat; legal range 1..48.
- `beats`, 4: beats per dot product; must be ≥1.
- `acc_width`, 16: match-count width; must be ≥ clog2(width*beats+1). Elaboration fails with `$error` if any parameter is out of range.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clear`  in  1  synchronous flush of the partial group.
- `in_valid`  in  1  `in_data` holds a beat.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  `width`  XNOR result beat.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_count`  out  `acc_width`  number of ones over the group.
- `out_dot`  out  `acc_width+1`  signed value, 2*out_count − width*beats.

## Operation
- A beat transfers on any cycle with `in_valid && in_ready`.
- **Stage 1 (`pc_q`, `pc_valid`):** registers popcount(`in_data`) for each accepted beat.
- **Stage 2 (`acc`, `beat_cnt`):**
  - When `pc_valid` and stage 2 advances, a non-final beat updates acc ← acc + pc_q and beat_cnt ← beat_cnt + 1.
  - The final beat (beat_cnt == beats−1) loads out_count ← acc + pc_q and out_dot, sets `out_valid`, and returns acc and beat_cnt to 0.
  - When beats = 1, every beat is final.
- Stage 2 advances unless a final beat is pending while `out_valid && !out_ready`.
- `in_ready` = !reset && !clear && (!pc_valid || stage 2 advances). Stalls therefore propagate back to the input.
- Output handshake:
  - `out_valid` falls on the edge with `out_ready` high, unless a new result loads on that same edge (back-to-back groups).
  - `out_count` and `out_dot` stay stable while `out_valid && !out_ready`.
- `clear`:
  - Zeroes pc_valid, acc and beat_cnt.
  - No beat is accepted in the `clear` cycle.
  - The output register and its handshake are unaffected.
  - When `clear` coincides with a pending final beat, `clear` wins and that group is discarded.
- Arithmetic:
  - Popcount and the accumulator are unsigned.
  - out_dot is computed at `acc_width+1` bits, two's complement.
  - No saturation is needed, given the `acc_width` rule.

## Timing
- Reset values: `out_valid`=0, `out_count`=0, `out_dot`=0, pc_valid=0, acc=0, beat_cnt=0.
- `in_ready` is 0 while `reset` is high and 1 on the first cycle after release (when `clear` is low).
- Latency: a final beat accepted at edge k gives `out_valid`=1 in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: 1 beat/cycle sustained with `out_ready` held high. No bubbles between groups.
- Reset asserted mid-group or mid-handshake drops all state immediately. No partial result is ever emitted.

## Structure
- Shared package `xnor_pkg`:
  - `localparam`s for the maximum width (48).
  - A `clog2`-based constant function used by the `acc_width` check.
  - The stage-2 FSM encoding type `acc_state_t` {IDLE, ACCUM, HOLD}:
    - IDLE = no partial group.
    - ACCUM = partial group in progress.
    - HOLD = final beat stalled on the output.
- One combinational sub-module, `bit_popcount #(width)`, implemented as an adder tree, output clog2(width+1) bits.

## Test plan
- width=8, beats=2, `out_ready`=1; beats 8'hFF, 8'hFF → `out_count`=16, `out_dot`=16, `out_valid` for one cycle, 2 cycles after the last beat.
- width=8, beats=2; beats 8'h00, 8'h0F → `out_count`=4, `out_dot`=−8.
- width=48, beats=4, continuous `in_valid`, `out_ready`=1, 12 random beats → 3 results back-to-back, each matching a reference-model popcount sum, `in_ready` never low.
- `out_ready` held low for 5 cycles with a second group completing behind it → `in_ready` drops, the first result holds stable, and both results emerge in order with none lost or duplicated.
- `clear` pulsed after beat 1 of a beats=4 group, then 4 all-ones beats at width=8 → single result `out_count`=32. The discarded beat does not contribute.
- `reset` asserted asynchronously mid-clock, mid-group and during `out_valid` → all outputs 0 immediately and `in_ready`=0 while asserted. After release, a fresh group is counted from zero.
